regfile_bank: RTL and testbench

//  Storage stage of the register file: DEPTH words of WIDTH bits, one write port.

---
 rtl/regfile_bank_pkg.sv | 7 +
 rtl/regfile_bank_if.sv | 16 +
 rtl/regfile_bank_register_word.sv | 16 +
 rtl/regfile_bank.sv | 52 +++++
 tb/tb_regfile_bank.sv | 115 +++++++++++
 5 files changed

// File: rtl/regfile_bank_pkg.sv
// regfile_bank_pkg: shared sizes and FSM state encoding for the register file
package regfile_bank_pkg;
   localparam int REG_WIDTH = 32;
   localparam int REG_DEPTH = 32;
   localparam int REG_ADDR_W = 5;
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/regfile_bank_if.sv
// regfile_bank_if: write handshake, clear control and flat word bus of the register bank
interface regfile_bank_if import regfile_bank_pkg::*; #(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_DEPTH,
   parameter int ADDR_W = REG_ADDR_W
);
   logic wr_valid;
   logic wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic clr_req;
   logic busy;
   logic [WIDTH*DEPTH-1:0] regs_flat;
   modport master(output wr_valid, wr_addr, wr_data, clr_req, input wr_ready, busy, regs_flat);
   modport slave(input wr_valid, wr_addr, wr_data, clr_req, output wr_ready, busy, regs_flat);
endinterface

// File: rtl/regfile_bank_register_word.sv
// register_word: one storage word with write enable and synchronous clear
module register_word #(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   input logic we,
   input logic clr,
   input logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (we) q <= d;
endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: DEPTH x WIDTH register storage with a valid/ready write port
// and a DEPTH-1 cycle clear-all sequence; word 0 is constant zero.
module regfile_bank import regfile_bank_pkg::*; #(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_DEPTH,
   parameter int ADDR_W = REG_ADDR_W
) (
   input logic clk,
   input logic rst_n,
   regfile_bank_if.slave bus
);
   state_t state, state_nx;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
   logic [WIDTH*DEPTH-1:0] flat;
   logic fire, last;
   assign bus.wr_ready = state == IDLE;
   assign bus.busy = state == CLEAR;
   assign bus.regs_flat = flat;
   assign fire = bus.wr_valid && bus.wr_ready;
   assign last = clr_cnt == ADDR_W'(DEPTH - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         clr_cnt <= '0;
      end else begin
         state <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   // clr_req is only honoured in IDLE, so a second request cannot extend a sequence
   always_comb begin
      state_nx = state;
      clr_cnt_nx = clr_cnt;
      if (state == IDLE) begin
         state_nx = bus.clr_req ? CLEAR : IDLE;
         clr_cnt_nx = bus.clr_req ? ADDR_W'(1) : '0;
      end else begin
         state_nx = last ? IDLE : CLEAR;
         clr_cnt_nx = last ? '0 : clr_cnt + 1'b1;
      end
   end
   assign flat[WIDTH-1:0] = '0;
   for (genvar g = 1; g < DEPTH; g++) begin : g_word
      register_word #(.WIDTH(WIDTH)) u_word (
         .clk(clk),
         .rst_n(rst_n),
         .we(fire && bus.wr_addr == ADDR_W'(g)),
         .clr(bus.busy && clr_cnt == ADDR_W'(g)),
         .d(bus.wr_data),
         .q(flat[g*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: randomized and directed stimulus against a word-array model,
// checked every cycle by a queue-based monitor.
module tb_regfile_bank;
   localparam int W = 32;
   localparam int D = 32;
   typedef struct {
      logic [W-1:0] w [D];
      logic b;
      logic r;
   } exp_t;
   logic clk = 0;
   logic rst_n = 0;
   int total = 0;
   int bad = 0;
   exp_t sb [$];
   logic [W-1:0] m [D];
   int cpos = -1;
   regfile_bank_if bus();
   regfile_bank dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < D; i++) m[i] = '0;
      cpos = -1;
   endtask
   // one clock edge of the model: writes only when not clearing, then the clear walk 1..D-1
   task automatic model_edge(input logic v, input logic [4:0] a, input logic [W-1:0] d, input logic c);
      exp_t e;
      if (cpos < 0) begin
         if (v && a != 0) m[a] = d;
         if (c) cpos = 1;
      end else begin
         m[cpos] = '0;
         cpos = (cpos == D - 1) ? -1 : cpos + 1;
      end
      e.w = m;
      e.b = cpos >= 0;
      e.r = cpos < 0;
      sb.push_back(e);
   endtask
   task automatic step(input logic v, input logic [4:0] a, input logic [W-1:0] d, input logic c);
      bus.wr_valid = v;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.clr_req = c;
      @(posedge clk);
      model_edge(v, a, d, c);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask
   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         for (int i = 0; i < D; i++) chk($sformatf("word%0d", i), bus.regs_flat[i*W +: W], e.w[i]);
         chk("busy", {31'b0, bus.busy}, {31'b0, e.b});
         chk("wr_ready", {31'b0, bus.wr_ready}, {31'b0, e.r});
      end
   task automatic chk_zero(input string tag);
      for (int i = 0; i < D; i++) chk($sformatf("%s_word%0d", tag, i), bus.regs_flat[i*W +: W], '0);
      chk({tag, "_busy"}, {31'b0, bus.busy}, '0);
      chk({tag, "_ready"}, {31'b0, bus.wr_ready}, 32'd1);
   endtask
   initial begin
      bus.wr_valid = 0;
      bus.wr_addr = 0;
      bus.wr_data = 0;
      bus.clr_req = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1;
      step(1, 5, 32'hDEADBEEF, 0);
      step(1, 0, 32'hFFFFFFFF, 0);
      idle(2);
      for (int a = 1; a < D; a++) step(1, 5'(a), 32'(a) * 32'h01010101, 0);
      idle(1);
      step(0, 0, 0, 1);
      idle(33);
      for (int a = 1; a < D; a++) step(1, 5'(a), $urandom, 0);
      step(1, 7, 32'h12345678, 1);
      for (int i = 0; i < 35; i++) step(1, 9, 32'hA5A5A5A5 + 32'(i), 0);
      idle(2);
      for (int a = 1; a < D; a++) step(1, 5'(a), $urandom, 0);
      step(0, 0, 0, 1);
      idle(9);
      #3 rst_n = 0;
      #1 chk_zero("async_rst");
      sb.delete();
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      for (int a = 1; a < D; a++) step(1, 5'(a), $urandom, 0);
      step(0, 0, 0, 1);
      idle(5);
      step(1, 3, 32'h0BAD0BAD, 1);
      idle(30);
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, 5'($urandom % D), $urandom, ($urandom % 50) == 0);
      idle(35);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
